fifo_var_par: RTL and testbench
===============================

Name: fifo_var_par

Overview:
- Next-generation parallel circular-buffer FIFO.
- Each write pushes 1..PAR_WRITE words and each read pops 1..PAR_READ words, with the count chosen per transaction.
- Adds ready/valid handshakes, an occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow flags.
- Sits between producers and consumers of different word-rates in the datapath; depth need not be a power of two.

Parameters:
- SIZE, 4, bits per word.
- MEM_SIZE, 6, depth in words, any value >= max(PAR_WRITE, PAR_READ); the elaboration check fails otherwise.
- PAR_WRITE, 2, maximum words per write.
- PAR_READ, 4, maximum words per read.
- AFULL_TH, 4, almost_full when count >= AFULL_TH.
- AEMPTY_TH, 2, almost_empty when count <= AEMPTY_TH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush.
- wen  in  1  write request.
- wcnt  in  $clog2(PAR_WRITE+1)  words in this write.
- din  in  PAR_WRITE*SIZE  write data; word i at [i*SIZE +: SIZE], word 0 enters first.
- ready  out  1  a write of wcnt words would be accepted.
- ren  in  1  read request.
- rcnt  in  $clog2(PAR_READ+1)  words in this read.
- dout  out  PAR_READ*SIZE  show-ahead data; lane j = j-th oldest word.
- valid  out  1  a read of rcnt words would be accepted.
- count  out  $clog2(MEM_SIZE+1)  current occupancy.
- full  out  1  count == MEM_SIZE.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- ovf  out  1  sticky: write attempted while not ready.
- udf  out  1  sticky: read attempted while not valid.

Behaviour:
- Reset (rst=1 at an edge):
  - wptr, rptr and count go to 0; ovf and udf go to 0.
  - Memory is not reset.
  - Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=(AFULL_TH==0), dout=0.
- Legal counts: wcnt in 1..PAR_WRITE, rcnt in 1..PAR_READ. A count of 0 or above the maximum is never accepted.
- ready (combinational) = !clear && wcnt legal && (MEM_SIZE - count) >= wcnt.
- valid (combinational) = !clear && rcnt legal && count >= rcnt.
- Write accept (w_acc = wen && ready):
  - mem[(wptr+i) mod MEM_SIZE] <= din word i, for i < wcnt.
  - wptr <= (wptr+wcnt) mod MEM_SIZE.
- Read accept (r_acc = ren && valid):
  - rptr <= (rptr+rcnt) mod MEM_SIZE.
- dout lane j:
  - mem[(rptr+j) mod MEM_SIZE] when j < count; 0 otherwise.
  - Combinational from registered state.
  - Latency: a word written at edge N is visible on dout after edge N.
- Simultaneous write and read:
  - Both are judged against pre-edge state; there is no bypass.
  - A write into a full FIFO is rejected even if a read frees space in the same cycle.
  - A read never returns same-cycle write data.
  - count <= count + (w_acc ? wcnt : 0) - (r_acc ? rcnt : 0).
- Flags:
  - ovf <= 1 when wen && !ready && !clear.
  - udf <= 1 when ren && !valid && !clear.
  - Both hold until rst or clear.
- clear:
  - Same state effect as rst; overrides wen/ren in the same cycle, so nothing is written or read.
  - ready=valid=0 while clear=1.
- Reset priority: rst over clear over normal operation. Reset mid-transfer discards all contents; no partial write survives.
- Wrap-around: all pointer arithmetic is modulo MEM_SIZE. A multi-word access may straddle the wrap boundary (e.g. wptr=5, wcnt=2 writes mem[5] and mem[0]).
- Rejected access: no state change apart from the sticky flag.

Decomposition:
- Package fifo_pkg:
  - clog2 width helper.
  - Derived widths: PTR_W, CNT_W, WCNT_W, RCNT_W.
  - Lane-slice helper macro.
- Sub-module fifo_ptr_adv:
  - Combinational modular adder: out = (ptr + n) mod MEM_SIZE for n <= MEM_SIZE, done with one conditional subtract.
  - Used for wptr, rptr and per-lane addresses.

Test Plan (SIZE=4, MEM_SIZE=6, PAR_WRITE=2, PAR_READ=4, AFULL_TH=4, AEMPTY_TH=2):
1. rst for 2 cycles, then wen=1, wcnt=2, din=8'h75 for one cycle:
   - count=2, dout=16'h0075, empty=0, almost_empty=1.
   - With rcnt=2: valid=1. With rcnt=3: valid=0.
2. Three writes of wcnt=2 (din=8'h21, 8'h43, 8'h65):
   - count=6, full=1, almost_full=1.
   - With wcnt=1: ready=0.
   - Another wen: ovf=1, count stays 6.
3. From state 2, read rcnt=4 (dout=16'h4321), then write wcnt=2 din=8'h87:
   - wptr wraps 0->2, count=4.
   - Next read rcnt=4 returns 16'h8765.
4. count=3 with wen wcnt=2 and ren rcnt=3 in the same cycle:
   - Both accepted, count=2, dout = the two new words.
   - Same setup with count=5: write rejected, ovf=1, read accepted, count=2.
5. count=4 with clear=1, wen=1, ren=1:
   - Next cycle count=0, empty=1, dout=0, ovf=udf=0, write discarded.
   - ren with rcnt=1 then sets udf=1.
6. rst asserted mid-sequence with wen=1:
   - Next cycle count=0, all flags reset, write discarded.
   - Normal operation resumes the cycle after rst deasserts.

Source files
------------

// File: rtl/fifo_pkg.sv
// Width helpers and lane-slice macro shared by the variable-parallelism FIFO files.
`define FIFO_LANE(vec, idx, w) vec[(idx)*(w) +: (w)]

package fifo_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = 1; v < n; v = v * 2) r++;
      return r;
   endfunction

   // PTR_W: pointer into a depth-entry ring, never narrower than one bit
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? clog2(depth) : 1;
   endfunction

   // CNT_W / WCNT_W / RCNT_W: a value that must reach maxv inclusive
   function automatic int cnt_w(input int maxv);
      return clog2(maxv + 1);
   endfunction

endpackage

// File: rtl/fifo_var_par_ptr_adv.sv
// Modular pointer advance (ptr + n) mod MEM_SIZE, combinational, no handshake.
// Valid for ptr < MEM_SIZE and n <= MEM_SIZE, so a single conditional subtract suffices.
module fifo_ptr_adv #(
   parameter int MEM_SIZE = 6,
   parameter int PTR_W    = 3,
   parameter int N_W      = 3
) (
   input  logic [PTR_W-1:0] ptr,
   input  logic [N_W-1:0]   n,
   output logic [PTR_W-1:0] res
);

   localparam int SUM_W = ((PTR_W > N_W) ? PTR_W : N_W) + 1;

   logic [SUM_W-1:0] sum;

   assign sum = SUM_W'(ptr) + SUM_W'(n);
   assign res = PTR_W'((sum >= SUM_W'(MEM_SIZE)) ? sum - SUM_W'(MEM_SIZE) : sum);

endmodule

// File: rtl/fifo_var_par.sv
// Ring FIFO pushing 1..PAR_WRITE and popping 1..PAR_READ words per cycle; show-ahead dout, write visible after one edge.
// ready/valid are combinational from pre-edge occupancy; refused accesses only set sticky ovf/udf.
module fifo_var_par
   import fifo_pkg::*;
#(
   parameter int SIZE      = 4,
   parameter int MEM_SIZE  = 6,
   parameter int PAR_WRITE = 2,
   parameter int PAR_READ  = 4,
   parameter int AFULL_TH  = 4,
   parameter int AEMPTY_TH = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            clear,
   input  logic                            wen,
   input  logic [cnt_w(PAR_WRITE)-1:0]     wcnt,
   input  logic [PAR_WRITE*SIZE-1:0]       din,
   output logic                            ready,
   input  logic                            ren,
   input  logic [cnt_w(PAR_READ)-1:0]      rcnt,
   output logic [PAR_READ*SIZE-1:0]        dout,
   output logic                            valid,
   output logic [cnt_w(MEM_SIZE)-1:0]      count,
   output logic                            full,
   output logic                            empty,
   output logic                            almost_full,
   output logic                            almost_empty,
   output logic                            ovf,
   output logic                            udf
);

   localparam int PTR_W  = ptr_w(MEM_SIZE);
   localparam int CNT_W  = cnt_w(MEM_SIZE);
   localparam int WCNT_W = cnt_w(PAR_WRITE);
   localparam int RCNT_W = cnt_w(PAR_READ);

   if (MEM_SIZE < PAR_WRITE || MEM_SIZE < PAR_READ) begin : g_bad_depth
      $error("fifo_var_par: MEM_SIZE must be >= max(PAR_WRITE, PAR_READ)");
   end

   logic [SIZE-1:0]  mem [MEM_SIZE];
   logic [PTR_W-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
   logic [PTR_W-1:0] waddr [PAR_WRITE];
   logic [PTR_W-1:0] raddr [PAR_READ];
   logic [CNT_W-1:0] space, count_nxt;
   logic             wcnt_ok, rcnt_ok, w_acc, r_acc;

   assign wcnt_ok = (wcnt != '0) && (int'(wcnt) <= PAR_WRITE);
   assign rcnt_ok = (rcnt != '0) && (int'(rcnt) <= PAR_READ);
   assign space   = CNT_W'(MEM_SIZE) - count;

   // Both sides judged on pre-edge occupancy: a read never frees room for a same-cycle write
   assign ready = !clear && wcnt_ok && (int'(wcnt) <= int'(space));
   assign valid = !clear && rcnt_ok && (int'(rcnt) <= int'(count));
   assign w_acc = wen && ready && !rst;
   assign r_acc = ren && valid && !rst;

   fifo_ptr_adv #(.MEM_SIZE(MEM_SIZE), .PTR_W(PTR_W), .N_W(WCNT_W)) u_wptr_adv (
      .ptr(wptr), .n(wcnt), .res(wptr_nxt)
   );

   fifo_ptr_adv #(.MEM_SIZE(MEM_SIZE), .PTR_W(PTR_W), .N_W(RCNT_W)) u_rptr_adv (
      .ptr(rptr), .n(rcnt), .res(rptr_nxt)
   );

   for (genvar i = 0; i < PAR_WRITE; i++) begin : g_waddr
      fifo_ptr_adv #(.MEM_SIZE(MEM_SIZE), .PTR_W(PTR_W), .N_W(WCNT_W)) u_adv (
         .ptr(wptr), .n(WCNT_W'(i)), .res(waddr[i])
      );
   end

   for (genvar j = 0; j < PAR_READ; j++) begin : g_raddr
      fifo_ptr_adv #(.MEM_SIZE(MEM_SIZE), .PTR_W(PTR_W), .N_W(RCNT_W)) u_adv (
         .ptr(rptr), .n(RCNT_W'(j)), .res(raddr[j])
      );
   end

   always_ff @(posedge clk) begin
      if (w_acc) begin
         for (int i = 0; i < PAR_WRITE; i++) begin
            if (i < int'(wcnt)) mem[waddr[i]] <= `FIFO_LANE(din, i, SIZE);
         end
      end
   end

   always_comb begin
      count_nxt = count;
      if (w_acc) count_nxt = count_nxt + CNT_W'(wcnt);
      if (r_acc) count_nxt = count_nxt - CNT_W'(rcnt);
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else begin
         if (w_acc) wptr <= wptr_nxt;
         if (r_acc) rptr <= rptr_nxt;
         count <= count_nxt;
         if (wen && !ready) ovf <= 1'b1;
         if (ren && !valid) udf <= 1'b1;
      end
   end

   // Lanes beyond the occupancy read as zero so stale or never-written memory stays hidden
   always_comb begin
      dout = '0;
      for (int j = 0; j < PAR_READ; j++) begin
         if (j < int'(count)) `FIFO_LANE(dout, j, SIZE) = mem[raddr[j]];
      end
   end

   assign full         = (count == CNT_W'(MEM_SIZE));
   assign empty        = (count == '0);
   assign almost_full  = (int'(count) >= AFULL_TH);
   assign almost_empty = (int'(count) <= AEMPTY_TH);

endmodule

// File: tb/tb_fifo_var_par.sv
// Table of per-cycle vectors with hand-derived handshakes/occupancy/flags; a word queue scoreboards dout.
module tb_fifo_var_par;

   logic        clk, rst, clear, wen, ren;
   logic [1:0]  wcnt;
   logic [7:0]  din;
   logic [2:0]  rcnt;
   logic        ready, valid;
   logic [15:0] dout;
   logic [2:0]  count;
   logic        full, empty, almost_full, almost_empty, ovf, udf;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int rst, clr, wen, wcnt, din, ren, rcnt;
      int e_ready, e_valid;   // pre-edge expectation, -1 = don't care
      int e_count, e_ovf, e_udf;
   } vec_t;

   vec_t       vt[$];
   logic [3:0] sbq[$];

   fifo_var_par dut (
      .clk(clk), .rst(rst), .clear(clear), .wen(wen), .wcnt(wcnt), .din(din),
      .ready(ready), .ren(ren), .rcnt(rcnt), .dout(dout), .valid(valid),
      .count(count), .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .ovf(ovf), .udf(udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input int r, c, w, wc, d, rd, rc, er, ev, ec, eo, eu);
      vec_t v;
      v.rst = r; v.clr = c; v.wen = w; v.wcnt = wc; v.din = d; v.ren = rd; v.rcnt = rc;
      v.e_ready = er; v.e_valid = ev; v.e_count = ec; v.e_ovf = eo; v.e_udf = eu;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input int idx, input vec_t v);
      logic [15:0] exp_dout;
      logic [3:0]  w;
      @(negedge clk);
      rst   = (v.rst != 0);
      clear = (v.clr != 0);
      wen   = (v.wen != 0);
      ren   = (v.ren != 0);
      wcnt  = 2'(v.wcnt);
      din   = 8'(v.din);
      rcnt  = 3'(v.rcnt);
      #1;
      if (v.e_ready >= 0) chk($sformatf("v%0d ready", idx), 32'(ready), 32'(v.e_ready));
      if (v.e_valid >= 0) chk($sformatf("v%0d valid", idx), 32'(valid), 32'(v.e_valid));
      if (v.rst == 0 && v.ren != 0 && v.e_valid == 1) begin
         for (int j = 0; j < v.rcnt; j++) begin
            w = sbq.pop_front();
            chk($sformatf("v%0d read lane%0d", idx, j), 32'(dout[j*4 +: 4]), 32'(w));
         end
      end
      if (v.rst == 0 && v.wen != 0 && v.e_ready == 1) begin
         for (int i = 0; i < v.wcnt; i++) sbq.push_back(din[i*4 +: 4]);
      end
      if (v.rst != 0 || v.clr != 0) sbq.delete();
      @(posedge clk);
      #1;
      chk($sformatf("v%0d count", idx), 32'(count), 32'(v.e_count));
      chk($sformatf("v%0d ovf", idx), 32'(ovf), 32'(v.e_ovf));
      chk($sformatf("v%0d udf", idx), 32'(udf), 32'(v.e_udf));
      chk($sformatf("v%0d full", idx), 32'(full), 32'(v.e_count == 6));
      chk($sformatf("v%0d empty", idx), 32'(empty), 32'(v.e_count == 0));
      chk($sformatf("v%0d almost_full", idx), 32'(almost_full), 32'(v.e_count >= 4));
      chk($sformatf("v%0d almost_empty", idx), 32'(almost_empty), 32'(v.e_count <= 2));
      exp_dout = '0;
      for (int j = 0; j < 4; j++) begin
         if (j < sbq.size()) exp_dout[j*4 +: 4] = sbq[j];
      end
      chk($sformatf("v%0d dout", idx), 32'(dout), 32'(exp_dout));
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; wen = 1'b0; ren = 1'b0;
      wcnt = '0; din = '0; rcnt = '0;

      //             rst clr wen wc din    ren rc  rdy vld cnt ovf udf
      vt.push_back(mk(1, 0, 0, 0, 'h00, 0, 0, -1, -1, 0, 0, 0));
      vt.push_back(mk(1, 0, 0, 0, 'h00, 0, 0,  0,  0, 0, 0, 0));
      vt.push_back(mk(0, 0, 1, 2, 'h75, 0, 2,  1,  0, 2, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 'h00, 0, 2,  0,  1, 2, 0, 0));
      vt.push_back(mk(0, 0, 0, 3, 'h00, 0, 3,  0,  0, 2, 0, 0));
      vt.push_back(mk(0, 1, 1, 2, 'hFF, 1, 1,  0,  0, 0, 0, 0));
      vt.push_back(mk(0, 0, 1, 2, 'h21, 0, 0,  1,  0, 2, 0, 0));
      vt.push_back(mk(0, 0, 1, 2, 'h43, 0, 0,  1,  0, 4, 0, 0));
      vt.push_back(mk(0, 0, 1, 2, 'h65, 0, 0,  1,  0, 6, 0, 0));
      vt.push_back(mk(0, 0, 0, 1, 'h00, 0, 0,  0,  0, 6, 0, 0));
      vt.push_back(mk(0, 0, 1, 1, 'h00, 0, 0,  0,  0, 6, 1, 0));
      vt.push_back(mk(0, 0, 0, 0, 'h00, 1, 4,  0,  1, 2, 1, 0));
      vt.push_back(mk(0, 0, 1, 2, 'h87, 0, 0,  1,  0, 4, 1, 0));
      vt.push_back(mk(0, 0, 0, 0, 'h00, 1, 4,  0,  1, 0, 1, 0));
      vt.push_back(mk(0, 0, 1, 2, 'hA9, 0, 0,  1,  0, 2, 1, 0));
      vt.push_back(mk(0, 0, 1, 1, 'h0B, 0, 0,  1,  0, 3, 1, 0));
      vt.push_back(mk(0, 0, 1, 2, 'hDC, 1, 3,  1,  1, 2, 1, 0));
      vt.push_back(mk(0, 1, 0, 0, 'h00, 0, 0,  0,  0, 0, 0, 0));
      vt.push_back(mk(0, 0, 1, 2, 'hFE, 0, 0,  1,  0, 2, 0, 0));
      vt.push_back(mk(0, 0, 1, 2, 'h10, 0, 0,  1,  0, 4, 0, 0));
      vt.push_back(mk(0, 0, 1, 1, 'h02, 0, 0,  1,  0, 5, 0, 0));
      vt.push_back(mk(0, 0, 1, 2, 'h43, 1, 3,  0,  1, 2, 1, 0));
      vt.push_back(mk(0, 0, 1, 2, 'h54, 0, 0,  1,  0, 4, 1, 0));
      vt.push_back(mk(0, 0, 0, 0, 'h00, 1, 5,  0,  0, 4, 1, 1));
      vt.push_back(mk(0, 1, 1, 1, 'h06, 1, 1,  0,  0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 'h00, 1, 1,  0,  0, 0, 0, 1));
      vt.push_back(mk(0, 0, 1, 2, 'h87, 0, 0,  1,  0, 2, 0, 1));
      vt.push_back(mk(0, 0, 1, 0, 'h00, 0, 0,  0,  0, 2, 1, 1));
      vt.push_back(mk(1, 0, 1, 2, 'hAA, 0, 0,  1,  0, 0, 0, 0));
      vt.push_back(mk(0, 0, 1, 2, 'hCB, 0, 0,  1,  0, 2, 0, 0));
      vt.push_back(mk(0, 0, 1, 1, 'h0D, 1, 2,  1,  1, 1, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 'h00, 1, 1,  0,  1, 0, 0, 0));

      for (int k = 0; k < vt.size(); k++) apply(k, vt[k]);

      // Single-word fill to full then drain, walking both pointers across the wrap
      for (int k = 0; k < 6; k++)
         apply(100 + k, mk(0, 0, 1, 1, k + 3, 0, 0, 1, 0, k + 1, 0, 0));
      apply(106, mk(0, 0, 1, 1, 'h0E, 0, 0, 0, 0, 6, 1, 0));
      for (int k = 0; k < 6; k++)
         apply(110 + k, mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 5 - k, 1, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
